// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: instruction and data caches share one AR/R channel pair.
// Alternating priority on contention, one outstanding burst, sticky protocol-error flag.
module axi_read_arbiter #(
   parameter logic [3:0] ID_INST = 4'd0,
   parameter logic [3:0] ID_DATA = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-cache AR / R
   input  logic [31:0] i_araddr,
   input  logic [7:0]  i_arlen,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rlast,
   output logic        i_rvalid,
   input  logic        i_rready,
   // data-cache AR / R
   input  logic [31:0] d_araddr,
   input  logic [7:0]  d_arlen,
   input  logic [2:0]  d_arsize,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rlast,
   output logic        d_rvalid,
   input  logic        d_rready,
   // shared AXI AR
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   // shared AXI R
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;            // 0 = inst, 1 = data
   logic        last_grant_q, last_grant_d;
   logic [7:0]  beat_cnt_q, beat_cnt_d;
   logic [7:0]  len_q, len_d;
   logic        err_q, err_d;

   logic        g_arvalid;
   logic        g_rready;
   logic [3:0]  g_id;
   logic        beat;
   logic        beat_bad;

   always_comb begin
      g_arvalid = grant_q ? d_arvalid : i_arvalid;
      g_rready  = grant_q ? d_rready  : i_rready;
      g_id      = grant_q ? ID_DATA   : ID_INST;
      beat      = (state_q == DATA) && rvalid && g_rready;
      beat_bad  = (rid != g_id) || (rresp != 2'b00) || (rlast != (beat_cnt_q == len_q));
   end

   // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      len_d        = len_q;
      err_d        = err_q;
      unique case (state_q)
         IDLE: begin
            if (i_arvalid || d_arvalid) begin
               grant_d = (i_arvalid && d_arvalid) ? ~last_grant_q : d_arvalid;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (!g_arvalid) begin
               state_d = IDLE;                 // request withdrawn: priority history untouched
            end else if (arready) begin
               state_d      = DATA;
               beat_cnt_d   = 8'd0;
               len_d        = grant_q ? d_arlen : i_arlen;
               last_grant_d = grant_q;
            end
         end
         DATA: begin
            if (beat) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (beat_bad) err_d = 1'b1;
               if (rlast) state_d = IDLE;      // only the slave's rlast ends the burst
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b0;
         beat_cnt_q   <= 8'd0;
         len_q        <= 8'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         len_q        <= len_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      arid      = 4'd0;
      araddr    = 32'd0;
      arlen     = 8'd0;
      arsize    = 3'd0;
      arburst   = 2'b01;
      arvalid   = 1'b0;
      i_arready = 1'b0;
      d_arready = 1'b0;
      rready    = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rlast   = 1'b0;
      d_rlast   = 1'b0;
      i_rdata   = 32'd0;
      d_rdata   = 32'd0;
      if (state_q == ADDR) begin
         arvalid   = g_arvalid;
         arid      = g_id;
         araddr    = grant_q ? d_araddr : i_araddr;
         arlen     = grant_q ? d_arlen  : i_arlen;
         arsize    = grant_q ? d_arsize : 3'b010;
         i_arready = !grant_q && arready;
         d_arready = grant_q && arready;
      end else if (state_q == DATA) begin
         rready   = g_rready;
         i_rdata  = rdata;
         d_rdata  = rdata;
         i_rvalid = !grant_q && rvalid;
         d_rvalid = grant_q && rvalid;
         i_rlast  = !grant_q && rvalid && rlast;
         d_rlast  = grant_q && rvalid && rlast;
      end
   end

   assign err = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: a transaction-level model predicts grant order,
// AR contents, R routing and the sticky error flag.
module tb_axi_read_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_araddr, d_araddr, araddr, i_rdata, d_rdata, rdata;
   logic [7:0]  i_arlen, d_arlen, arlen;
   logic [2:0]  d_arsize, arsize;
   logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
   logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
   logic [3:0]  arid, rid;
   logic [1:0]  arburst, rresp;
   logic        arvalid, arready, rlast, rvalid, rready, err;

   int n_vec = 0;
   int n_err = 0;
   bit m_last_grant;
   bit m_err;

   localparam logic [56:0] QUIET = 57'd128;   // all flags/fields zero, arburst = INCR

   logic [56:0] out_vec;
   assign out_vec = {arvalid, arid, araddr, arlen, arsize, arburst,
                     rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast};

   always #5 clk = ~clk;

   axi_read_arbiter dut (
      .clk(clk), .rst(rst),
      .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
      .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
      .d_rready(d_rready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .err(err)
   );

   typedef struct {
      bit          req_i, req_d;
      logic [31:0] addr_i, addr_d;
      logic [7:0]  len_i, len_d;
      logic [2:0]  size_d;
      int          ar_delay;
      int          last_at;       // beat index carrying rlast, -1 = arlen
      int          bad_resp_at;
      int          bad_rid_at;
      int          stop_after;    // return mid-burst after this many beats, -1 = never
      bit          full_rate;
   } txn_t;

   function automatic bit rbit(int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   function automatic txn_t rand_txn(bit ri, bit rd);
      txn_t t;
      t.req_i       = ri;
      t.req_d       = rd;
      t.addr_i      = $urandom;
      t.addr_d      = $urandom;
      t.len_i       = 8'($urandom_range(0, 6));
      t.len_d       = 8'($urandom_range(0, 6));
      t.size_d      = 3'($urandom_range(0, 7));
      t.ar_delay    = $urandom_range(0, 2);
      t.last_at     = -1;
      t.bad_resp_at = -1;
      t.bad_rid_at  = -1;
      t.stop_after  = -1;
      t.full_rate   = 1'b0;
      return t;
   endfunction

   task automatic drop_inputs();
      i_arvalid = 1'b0; d_arvalid = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rresp = 2'b00; rdata = 32'd0;
      i_rready = 1'b0; d_rready = 1'b0;
   endtask

   // Entered just after a rising edge with the DUT idle; returns just after the edge that took rlast.
   task automatic run_txn(input txn_t t, input string tag);
      bit          g, v, gr, done;
      logic [3:0]  gid;
      logic [31:0] gaddr;
      logic [7:0]  glen;
      logic [2:0]  gsize;
      logic [56:0] exp;
      int          last, k, cyc, nobs;
      g     = (t.req_i && t.req_d) ? !m_last_grant : t.req_d;
      gid   = g ? 4'd1 : 4'd0;
      gaddr = g ? t.addr_d : t.addr_i;
      glen  = g ? t.len_d : t.len_i;
      gsize = g ? t.size_d : 3'b010;
      last  = (t.last_at < 0) ? int'(glen) : t.last_at;

      i_arvalid = t.req_i; i_araddr = t.addr_i; i_arlen = t.len_i;
      d_arvalid = t.req_d; d_araddr = t.addr_d; d_arlen = t.len_d; d_arsize = t.size_d;
      arready = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_vec !== QUIET) begin
         n_err++; $display("FAIL %s idle: got %h expected %h", tag, out_vec, QUIET);
      end
      n_vec++;
      if (err !== m_err) begin
         n_err++; $display("FAIL %s err_at_start: got %b expected %b", tag, err, m_err);
      end
      @(posedge clk); #1;

      for (int c = 0; c <= t.ar_delay; c++) begin
         arready  = (c == t.ar_delay);
         rvalid   = rbit(50); rlast = rbit(50); rid = 4'($urandom_range(0, 15));
         i_rready = rbit(50); d_rready = rbit(50);
         @(negedge clk);
         exp = {1'b1, gid, gaddr, glen, gsize, 2'b01, 1'b0, !g && arready, g && arready, 4'b0000};
         n_vec++;
         if (out_vec !== exp) begin
            n_err++; $display("FAIL %s addr_phase: got %h expected %h", tag, out_vec, exp);
         end
         @(posedge clk); #1;
      end
      m_last_grant = g;
      arready = 1'b0;
      if (g) d_arvalid = 1'b0; else i_arvalid = 1'b0;

      k = 0; done = 1'b0; cyc = 0; nobs = 0;
      while (!done && cyc < 1000) begin
         v  = t.full_rate ? 1'b1 : rbit(75);
         gr = t.full_rate ? 1'b1 : rbit(75);
         rvalid = v;
         rdata  = $urandom;
         rid    = (k == t.bad_rid_at) ? (gid ^ 4'h1) : gid;
         rresp  = (k == t.bad_resp_at) ? 2'b10 : 2'b00;
         rlast  = (k == last);
         if (g) begin d_rready = gr; i_rready = rbit(50); end
         else   begin i_rready = gr; d_rready = rbit(50); end
         @(negedge clk);
         exp = {1'b0, 4'd0, 32'd0, 8'd0, 3'd0, 2'b01, gr, 2'b00,
                !g && v, g && v, !g && v && rlast, g && v && rlast};
         n_vec++;
         if (out_vec !== exp) begin
            n_err++; $display("FAIL %s data_phase beat %0d: got %h expected %h", tag, k, out_vec, exp);
         end
         n_vec++;
         if ((g ? d_rdata : i_rdata) !== rdata) begin
            n_err++; $display("FAIL %s rdata: got %h expected %h", tag, g ? d_rdata : i_rdata, rdata);
         end
         n_vec++;
         if (err !== m_err) begin
            n_err++; $display("FAIL %s err: got %b expected %b", tag, err, m_err);
         end
         if (g ? (d_rvalid && d_rready) : (i_rvalid && i_rready)) nobs++;
         @(posedge clk);
         cyc++;
         if (v && gr) begin
            if (rid !== gid || rresp !== 2'b00 || ((k == int'(glen)) != rlast)) m_err = 1'b1;
            k++;
            if (rlast) done = 1'b1;
            else if (k == t.stop_after) begin #1; return; end
         end
         #1;
      end
      n_vec++;
      if (!done) begin
         n_err++; $display("FAIL %s timeout: got %0d beats expected %0d", tag, k, last + 1);
      end
      n_vec++;
      if (nobs != last + 1) begin
         n_err++; $display("FAIL %s beat_count: got %0d expected %0d", tag, nobs, last + 1);
      end
      drop_inputs();
   endtask

   task automatic apply_reset(input string tag);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if ({out_vec, err} !== {QUIET, 1'b0}) begin
         n_err++; $display("FAIL %s reset_outputs: got %h expected %h", tag, {out_vec, err}, {QUIET, 1'b0});
      end
      drop_inputs();
      @(posedge clk); #1;
      rst = 1'b1;
      m_last_grant = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i_arvalid = 1'b1; d_arvalid = 1'b1; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
      i_rready = 1'b1; d_rready = 1'b1; rid = 4'd1; rresp = 2'b10; rdata = 32'hdead_beef;
      i_araddr = 32'h1234_5678; d_araddr = 32'h9abc_def0; i_arlen = 8'd3; d_arlen = 8'd5; d_arsize = 3'd7;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({out_vec, err} !== {QUIET, 1'b0}) begin
            n_err++; $display("FAIL reset_hold: got %h expected %h", {out_vec, err}, {QUIET, 1'b0});
         end
      end
      @(posedge clk); #1;
      drop_inputs();
      rst = 1'b1;
      m_last_grant = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic test_inst_burst();
      txn_t t = rand_txn(1'b1, 1'b0);
      t.addr_i = 32'hBFC0_0000; t.len_i = 8'd7; t.ar_delay = 1; t.full_rate = 1'b1;
      run_txn(t, "inst_burst");
   endtask

   task automatic test_arbitration();
      apply_reset("arb");
      run_txn(rand_txn(1'b1, 1'b1), "arb_first_data");
      run_txn(rand_txn(1'b1, 1'b1), "arb_then_inst");
      run_txn(rand_txn(1'b1, 1'b1), "arb_then_data");
   endtask

   task automatic test_single_beat();
      txn_t t = rand_txn(1'b0, 1'b1);
      t.len_d = 8'd0; t.size_d = 3'd0; t.ar_delay = 0; t.full_rate = 1'b1;
      run_txn(t, "single_beat");
   endtask

   task automatic test_early_last();
      txn_t t;
      apply_reset("early_last");
      t = rand_txn(1'b1, 1'b0);
      t.len_i = 8'd7; t.last_at = 3;
      run_txn(t, "early_last");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_vec++;
         if ({out_vec, err} !== {QUIET, 1'b1}) begin
            n_err++; $display("FAIL early_last_held: got %h expected %h", {out_vec, err}, {QUIET, 1'b1});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_resp_rid_errors();
      txn_t t;
      apply_reset("bad_resp");
      t = rand_txn(1'b1, 1'b0);
      t.len_i = 8'd4; t.bad_resp_at = $urandom_range(0, 4);
      run_txn(t, "bad_resp");
      @(negedge clk);
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL bad_resp_err: got %b expected 1", err); end
      @(posedge clk); #1;
      apply_reset("bad_rid");
      t = rand_txn(1'b1, 1'b0);
      t.len_i = 8'd3; t.bad_rid_at = 2;
      run_txn(t, "bad_rid");
      @(negedge clk);
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL bad_rid_err: got %b expected 1", err); end
      @(posedge clk); #1;
      apply_reset("clean");
      run_txn(rand_txn(1'b0, 1'b1), "clean_data");
      @(negedge clk);
      n_vec++;
      if (err !== 1'b0) begin n_err++; $display("FAIL clean_err: got %b expected 0", err); end
      @(posedge clk); #1;
   endtask

   task automatic test_addr_abort();
      logic [56:0] exp;
      apply_reset("abort");
      d_arvalid = 1'b1; d_araddr = $urandom; d_arlen = 8'd2; d_arsize = 3'd1; arready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      exp = {1'b1, 4'd1, d_araddr, 8'd2, 3'd1, 2'b01, 7'd0};
      n_vec++;
      if (out_vec !== exp) begin
         n_err++; $display("FAIL abort_addr: got %h expected %h", out_vec, exp);
      end
      d_arvalid = 1'b0;
      @(posedge clk); #1;
      run_txn(rand_txn(1'b1, 1'b1), "after_abort");
   endtask

   task automatic test_reset_mid_burst();
      txn_t t;
      apply_reset("mid_pre");
      t = rand_txn(1'b1, 1'b0);
      t.len_i = 8'd7; t.full_rate = 1'b1; t.bad_resp_at = 0; t.stop_after = 3;
      run_txn(t, "mid_burst");
      n_vec++;
      if (err !== 1'b1) begin n_err++; $display("FAIL mid_err_before: got %b expected 1", err); end
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if ({out_vec, err} !== {QUIET, 1'b0}) begin
         n_err++; $display("FAIL mid_reset: got %h expected %h", {out_vec, err}, {QUIET, 1'b0});
      end
      @(posedge clk); #1;
      drop_inputs();
      rst = 1'b1;
      m_last_grant = 1'b0;
      m_err = 1'b0;
      run_txn(rand_txn(1'b0, 1'b1), "after_mid_reset");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 30; n++) begin
         int pat = $urandom_range(1, 3);
         run_txn(rand_txn(pat[0], pat[1]), "random");
      end
   endtask

   task automatic test_long_burst();
      txn_t t = rand_txn(1'b0, 1'b1);
      t.len_d = 8'd255; t.full_rate = 1'b1;
      run_txn(t, "long_burst");
      @(negedge clk);
      n_vec++;
      if ({out_vec, err} !== {QUIET, m_err}) begin
         n_err++; $display("FAIL long_burst_end: got %h expected %h", {out_vec, err}, {QUIET, m_err});
      end
   endtask

   initial begin
      test_reset();
      test_inst_burst();
      test_arbitration();
      test_single_beat();
      test_early_last();
      test_resp_rid_errors();
      test_addr_abort();
      test_reset_mid_burst();
      test_back_to_back();
      test_long_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
